stim_trigger_scheduler: RTL and testbench
=========================================

Name: stim_trigger_scheduler

Overview:
Arbitrates stimulation requests from up to N_REQ per-channel window discriminators (fsm_stim events) onto one shared stimulator trigger line. It enforces a programmable pulse width, a post-pulse refractory period and an optional per-session stim budget. It runs in the sample-clock domain, one decision per amplifier sample, and sits between the discriminator bank and the stimulator/digital-out logic.

Parameters:
N_REQ, 8, number of requesting channels (2..16)
CNT_W, 16, width of pulse-width, refractory, budget and counter fields
IDX_W, 3, width of channel index (equals ceil(log2(N_REQ)))

Ports:
sample_CLK_out  in   1      clock; one rising edge per amplifier sample
reset           in   1      synchronous, active-high
enable          in   1      scheduler enable; low aborts and flushes
req             in   N_REQ  one-sample stim request per channel
pulse_width     in   CNT_W  stim_out high time in samples; 0 treated as 1
refractory      in   CNT_W  forced low time after each pulse in samples
max_stims       in   CNT_W  stim budget; 0 means unlimited
clear_count     in   1      zeroes stim_count and releases LOCKOUT
stim_out        out  1      registered trigger to stimulator
stim_chan       out  IDX_W  index of channel owning current/last pulse
grant           out  N_REQ  one-hot, high for the single sample a request is granted
pending         out  N_REQ  latched, not-yet-served requests
busy            out  1      high in PULSE or REFRAC
locked          out  1      high in LOCKOUT
stim_count      out  CNT_W  pulses issued, saturating at all-ones
drop_count      out  CNT_W  requests merged into an already-pending bit, saturating

Behaviour:
- Reset, taking priority over all else: state=IDLE; all outputs 0; pending=0; counters=0; rr pointer=N_REQ-1, so channel 0 has first priority.
- Pending capture, every edge while enable=1: pending[i] <= (pending[i] & ~grant_clr[i]) | req[i]. Set wins over clear in the same edge.
- If req[i]=1 while pending[i]=1 and the bit is not cleared in that edge, drop_count increments (saturating).
- States: IDLE, PULSE, REFRAC, LOCKOUT (encodings 0..3).
- IDLE:
  - If enable and |pending, grant the first set pending bit searching round-robin from rr_ptr+1 with wrap.
  - On that grant: grant one-hot for 1 cycle; stim_chan <= index; rr_ptr <= index; clear the pending bit; stim_out <= 1; cnt <= max(pulse_width,1)-1; stim_count++ (saturating); go to PULSE.
- PULSE:
  - If cnt != 0, decrement.
  - If cnt == 0: stim_out <= 0. Go to REFRAC with cnt <= refractory-1 when refractory != 0.
  - If refractory == 0, go straight to the post-refractory check below.
- REFRAC: decrement cnt; at cnt == 0, do the post-refractory check.
- Post-refractory check: if max_stims != 0 and stim_count >= max_stims, go to LOCKOUT; otherwise go to IDLE.
- LOCKOUT: stim_out=0; no grants; pending keeps accumulating. clear_count returns to IDLE.
- clear_count, in any state: stim_count <= 0 next edge; it does not abort a pulse in progress.
- Timing guarantees:
  - stim_out is high for exactly max(pulse_width,1) consecutive edges.
  - stim_out is low for at least refractory+1 edges between pulses (the extra edge is IDLE arbitration).
- Latency: req high at edge k → pending at k → stim_out=1 after edge k+1 (if IDLE).
- enable=0 in any state, on the next edge: IDLE; stim_out=0; pending=0; grant=0; stim_count, drop_count and rr_ptr are held.
- Config inputs are sampled only at load points (IDLE grant, PULSE exit). Mid-pulse changes take effect on the next pulse.
- Reset mid-pulse: stim_out drops at that edge.

Decomposition:
- stim_sched_pkg: state encodings, CNT_W/IDX_W defaults, saturating-increment function.
- Sub-module rr_arbiter (combinational: pending, rr_ptr → one-hot grant + index + valid), reusable for other multi-channel resources.

Test Plan:
- Single request: pulse_width=3, refractory=5, req[2] at edge 10 → stim_out high on edges 11-13; stim_chan=2; grant[2] at 11; busy through edge 19; next grant possible at edge 20.
- Contention: req=8'b1000_0101 in one sample, pw=1, ref=0 → grants to channels 0, 2, 7 in that order on consecutive 2-edge slots; then req[0] and req[2] together → grant 0 (round-robin from 7).
- Drop/merge: req[1] repeated 3 times during a 10-sample refractory → drop_count=2; exactly one further pulse on channel 1.
- Budget: max_stims=2, repeated requests → 2 pulses then locked=1 and stim_out held 0; clear_count → stim_count=0, locked=0, pending request served.
- Abort: enable=0 during PULSE (cycle 2 of pw=5) → stim_out=0 and pending=0 next edge; re-enable with req[4] → normal pulse.
- Edge values: pulse_width=0 → 1-sample pulse; stim_count saturates at 16'hFFFF with max_stims=0; reset asserted mid-REFRAC → all outputs 0 on that edge.

Source files
------------

// File: rtl/stim_sched_pkg.sv
// Shared state encoding, default widths and a saturating adder for the
// stimulation trigger scheduler.
package stim_sched_pkg;
   localparam int DEF_N_REQ = 8;
   localparam int DEF_CNT_W = 16;
   localparam int DEF_IDX_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PULSE   = 2'd1,
      ST_REFRAC  = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_t;

   // Saturating add for fields up to 32 bits; lim is the field's all-ones value.
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] lim);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > {1'b0, lim}) ? lim : s[31:0];
   endfunction
endpackage

// File: rtl/stim_trigger_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set pending bit after rr_ptr, with wrap.
module rr_arbiter #(
   parameter int N_REQ = 8,
   parameter int IDX_W = 3
) (
   input  logic [N_REQ-1:0] pending,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);
   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!valid && pending[IDX_W'((int'(rr_ptr) + k) % N_REQ)]) begin
            valid      = 1'b1;
            idx        = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            grant[idx] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/stim_trigger_scheduler.sv
// Arbitrates per-channel stim requests onto one trigger line with pulse width,
// refractory period and an optional stim budget.
module stim_trigger_scheduler
   import stim_sched_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int CNT_W = DEF_CNT_W,
   parameter int IDX_W = DEF_IDX_W
) (
   input  logic             sample_CLK_out,
   input  logic             reset,
   input  logic             enable,
   input  logic [N_REQ-1:0] req,
   input  logic [CNT_W-1:0] pulse_width,
   input  logic [CNT_W-1:0] refractory,
   input  logic [CNT_W-1:0] max_stims,
   input  logic             clear_count,
   output logic             stim_out,
   output logic [IDX_W-1:0] stim_chan,
   output logic [N_REQ-1:0] grant,
   output logic [N_REQ-1:0] pending,
   output logic             busy,
   output logic             locked,
   output logic [CNT_W-1:0] stim_count,
   output logic [CNT_W-1:0] drop_count
);
   localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             stim_nxt, lock_hit, do_grant, arb_vld;
   logic [IDX_W-1:0] rr_ptr, arb_idx;
   logic [N_REQ-1:0] arb_grant, grant_clr, merged;

   rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
      .pending (pending),
      .rr_ptr  (rr_ptr),
      .grant   (arb_grant),
      .idx     (arb_idx),
      .valid   (arb_vld)
   );

   assign do_grant  = enable && (state == ST_IDLE) && arb_vld;
   assign grant_clr = do_grant ? arb_grant : '0;
   assign merged    = req & pending & ~grant_clr;
   // A clear on the check edge itself releases the budget rather than locking.
   assign lock_hit  = (max_stims != '0) && (stim_count >= max_stims) && !clear_count;
   assign busy      = (state == ST_PULSE) || (state == ST_REFRAC);
   assign locked    = (state == ST_LOCKOUT);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stim_nxt  = stim_out;
      case (state)
         ST_IDLE: if (do_grant) begin
            state_nxt = ST_PULSE;
            stim_nxt  = 1'b1;
            cnt_nxt   = (pulse_width == '0) ? '0 : pulse_width - CNT_W'(1);
         end
         ST_PULSE: if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
         end else begin
            stim_nxt = 1'b0;
            if (refractory != '0) begin
               state_nxt = ST_REFRAC;
               cnt_nxt   = refractory - CNT_W'(1);
            end else begin
               state_nxt = lock_hit ? ST_LOCKOUT : ST_IDLE;
            end
         end
         ST_REFRAC: if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
                    else           state_nxt = lock_hit ? ST_LOCKOUT : ST_IDLE;
         ST_LOCKOUT: begin
            stim_nxt = 1'b0;
            if (clear_count) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (!enable) begin
         state_nxt = ST_IDLE;
         stim_nxt  = 1'b0;
         cnt_nxt   = '0;
      end
   end

   always_ff @(posedge sample_CLK_out) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         stim_out   <= 1'b0;
         stim_chan  <= '0;
         grant      <= '0;
         pending    <= '0;
         rr_ptr     <= IDX_W'(N_REQ - 1);
         stim_count <= '0;
         drop_count <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         stim_out <= stim_nxt;
         grant    <= grant_clr;
         if (do_grant) begin
            stim_chan <= arb_idx;
            rr_ptr    <= arb_idx;
         end
         if (enable) begin
            pending    <= (pending & ~grant_clr) | req;
            drop_count <= CNT_W'(sat_add(32'(drop_count), 32'($countones(merged)), CNT_MAX));
         end else begin
            pending <= '0;
         end
         if (clear_count)   stim_count <= '0;
         else if (do_grant) stim_count <= CNT_W'(sat_add(32'(stim_count), 32'd1, CNT_MAX));
      end
   end
endmodule

// File: tb/tb_stim_trigger_scheduler.sv
// Scoreboard bench: a timing-arithmetic model predicts grants; a negedge monitor
// pops and compares each grant and each stim_out pulse width.
module tb_stim_trigger_scheduler;
   localparam int N = 8, CW = 8, IW = 3, CMAX = 255;

   logic          clk = 1'b0;
   logic          reset, enable, clear_count;
   logic [N-1:0]  req;
   logic [CW-1:0] pulse_width, refractory, max_stims;
   logic          stim_out, busy, locked;
   logic [IW-1:0] stim_chan;
   logic [N-1:0]  grant, pending;
   logic [CW-1:0] stim_count, drop_count;

   always #5 clk = ~clk;

   stim_trigger_scheduler #(.N_REQ(N), .CNT_W(CW), .IDX_W(IW)) dut (
      .sample_CLK_out(clk), .reset(reset), .enable(enable), .req(req),
      .pulse_width(pulse_width), .refractory(refractory), .max_stims(max_stims),
      .clear_count(clear_count), .stim_out(stim_out), .stim_chan(stim_chan),
      .grant(grant), .pending(pending), .busy(busy), .locked(locked),
      .stim_count(stim_count), .drop_count(drop_count)
   );

   typedef struct {int ed; int ch;} exp_t;
   exp_t exp_q[$];
   exp_t e;

   int total = 0, bad = 0;
   int t = 0, rr_m = N - 1, cnt_m = 0, drop_m = 0, free_at = 0, check_edge = -1;
   int g_edge = -1000, run_exp = 0, hi_run = 0;
   logic [N-1:0] pend_m = '0;
   bit locked_m = 0;

   task automatic chk(input string nm, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, want, t);
      end
   endtask

   // Pulse occupies max(pw,1) edges, then refractory edges, then one IDLE edge.
   task automatic model_update();
      logic [N-1:0] clr;
      int c, w;
      t++;
      clr = '0;
      if (reset) begin
         pend_m = '0; rr_m = N - 1; cnt_m = 0; drop_m = 0; locked_m = 0;
         free_at = t + 1; check_edge = -1; g_edge = -1000;
         exp_q.delete();
      end else if (!enable) begin
         if (t > g_edge && t - g_edge < run_exp) run_exp = t - g_edge;
         pend_m = '0; locked_m = 0; free_at = t + 1; check_edge = -1;
         if (clear_count) cnt_m = 0;
      end else begin
         if (!locked_m && t >= free_at && pend_m != '0) begin
            c = -1;
            for (int k = 1; k <= N; k++)
               if (c < 0 && pend_m[3'((rr_m + k) % N)]) c = (rr_m + k) % N;
            clr[3'(c)] = 1'b1;
            rr_m = c;
            exp_q.push_back('{ed: t, ch: c});
            g_edge = t;
            w = (pulse_width == '0) ? 1 : int'(pulse_width);
            run_exp = w;
            check_edge = t + w + int'(refractory);
            free_at = check_edge + 1;
            if (cnt_m < CMAX) cnt_m++;
         end
         if (locked_m && clear_count) locked_m = 0;
         else if (t == check_edge && max_stims != '0 && cnt_m >= int'(max_stims) && !clear_count)
            locked_m = 1;
         drop_m += $countones(req & pend_m & ~clr);
         if (drop_m > CMAX) drop_m = CMAX;
         pend_m = (pend_m & ~clr) | req;
         if (clear_count) cnt_m = 0;
      end
   endtask

   task automatic step(input logic [N-1:0] r);
      req = r;
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while (!((pend_m == '0 || locked_m) && t + 1 >= free_at) && n < 400) begin
         step('0);
         n++;
      end
      chk("drain_bound", int'(n < 400), 1);
      step('0);
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_stim_count"}, int'(stim_count), cnt_m);
      chk({tag, "_drop_count"}, int'(drop_count), drop_m);
      chk({tag, "_pending"}, int'(pending), int'(pend_m));
      chk({tag, "_locked"}, int'(locked), int'(locked_m));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_stim_out"}, int'(stim_out), 0);
      chk({tag, "_stim_chan"}, int'(stim_chan), 0);
      chk({tag, "_grant"}, int'(grant), 0);
      chk({tag, "_pending"}, int'(pending), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_locked"}, int'(locked), 0);
      chk({tag, "_stim_count"}, int'(stim_count), 0);
      chk({tag, "_drop_count"}, int'(drop_count), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step('0);
      step('0);
      reset = 1'b0;
      step('0);
   endtask

   always @(negedge clk) begin
      if (reset) begin
         hi_run = 0;
      end else begin
         if (grant != '0) begin
            if (exp_q.size() == 0) begin
               chk("grant_unexpected", int'(grant), 0);
            end else begin
               e = exp_q.pop_front();
               chk("grant_edge", t, e.ed);
               chk("grant_vec", int'(grant), 1 << e.ch);
               chk("stim_chan", int'(stim_chan), e.ch);
            end
         end
         if (stim_out) hi_run++;
         else if (hi_run != 0) begin
            chk("pulse_width", hi_run, run_exp);
            hi_run = 0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      logic [N-1:0] r;
      reset = 1'b1; enable = 1'b1; clear_count = 1'b0; req = '0;
      pulse_width = 8'd3; refractory = 8'd5; max_stims = 8'd0;
      step('0);
      chk_zero("reset");
      step('0);
      reset = 1'b0;
      step('0);

      // single request, plus a re-request during the pulse
      step(8'h04); t0 = t;
      step('0);
      chk("single_stim_hi", int'(stim_out), 1);
      chk("single_chan", int'(stim_chan), 2);
      chk("single_busy", int'(busy), 1);
      step(8'h04); step('0);
      chk("single_stim_last", int'(stim_out), 1);
      step('0);
      chk("single_stim_lo", int'(stim_out), 0);
      repeat (4) step('0);
      chk("single_busy_refrac", int'(busy), 1);
      step('0);
      chk("single_busy_done", int'(busy), 0);
      chk("single_edge", t - t0, 9);
      drain();
      chk_model("single");

      // contention
      do_reset();
      pulse_width = 8'd1; refractory = 8'd0;
      step(8'h85);
      step('0); chk("cont_first", int'(stim_chan), 0);
      step('0); step('0); chk("cont_second", int'(stim_chan), 2);
      step('0); step('0); chk("cont_third", int'(stim_chan), 7);
      step(8'h05);
      step('0); chk("cont_wrap", int'(stim_chan), 0);
      step('0); step('0); chk("cont_wrap2", int'(stim_chan), 2);
      drain();
      chk_model("cont");

      // drop / merge during a long refractory
      do_reset();
      pulse_width = 8'd1; refractory = 8'd10;
      step(8'h02); step('0); step('0);
      step(8'h02); step('0); step(8'h02); step('0); step(8'h02);
      chk("drop_count2", int'(drop_count), 2);
      chk("drop_pending", int'(pending), 8'h02);
      drain();
      chk("drop_stims", int'(stim_count), 2);
      chk_model("drop");

      // budget and lockout
      do_reset();
      pulse_width = 8'd2; refractory = 8'd1; max_stims = 8'd2;
      repeat (14) step(8'h08);
      chk("budget_locked", int'(locked), 1);
      chk("budget_count", int'(stim_count), 2);
      chk("budget_stim_lo", int'(stim_out), 0);
      chk("budget_pending", int'(pending), 8'h08);
      repeat (3) step(8'h08);
      chk("budget_still_locked", int'(locked), 1);
      clear_count = 1'b1; step('0); clear_count = 1'b0;
      chk("budget_clr_count", int'(stim_count), 0);
      chk("budget_clr_locked", int'(locked), 0);
      step('0);
      chk("budget_served", int'(stim_out), 1);
      chk("budget_count1", int'(stim_count), 1);
      drain();
      chk_model("budget");
      max_stims = 8'd0;

      // abort mid-pulse
      do_reset();
      pulse_width = 8'd5; refractory = 8'd2;
      step(8'h02); step('0); step(8'h40);
      enable = 1'b0; step('0);
      chk("abort_stim", int'(stim_out), 0);
      chk("abort_pending", int'(pending), 0);
      chk("abort_busy", int'(busy), 0);
      enable = 1'b1;
      step(8'h10);
      step('0);
      chk("abort_regrant", int'(stim_chan), 4);
      drain();
      chk_model("abort");

      // zero pulse width
      pulse_width = 8'd0; refractory = 8'd0;
      step(8'h20); step('0);
      chk("pw0_hi", int'(stim_out), 1);
      step('0);
      chk("pw0_lo", int'(stim_out), 0);
      drain();

      // counter saturation
      do_reset();
      pulse_width = 8'd1; refractory = 8'd0;
      repeat (600) step(8'hFF);
      chk("sat_stim_count", int'(stim_count), CMAX);
      chk("sat_drop_count", int'(drop_count), CMAX);
      drain();

      // reset during refractory
      pulse_width = 8'd1; refractory = 8'd8;
      step(8'h01); step('0); step('0); step('0);
      chk("refrac_busy", int'(busy), 1);
      reset = 1'b1; step('0);
      chk_zero("rst_refrac");
      reset = 1'b0; step('0);

      // randomized blocks
      for (int b = 0; b < 6; b++) begin
         pulse_width = 8'($urandom_range(0, 4));
         refractory  = 8'($urandom_range(0, 6));
         max_stims   = (b >= 4) ? 8'($urandom_range(2, 6)) : 8'd0;
         repeat (300) begin
            r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            enable = ($urandom_range(0, 59) != 0);
            clear_count = (max_stims != '0) && ($urandom_range(0, 39) == 0);
            step(r);
         end
         enable = 1'b1; clear_count = 1'b0;
         drain();
         if (locked_m) begin
            clear_count = 1'b1; step('0); clear_count = 1'b0;
            drain();
         end
         chk_model("rand");
      end

      max_stims = 8'd0;
      if (locked_m) begin
         clear_count = 1'b1; step('0); clear_count = 1'b0;
      end
      drain();
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
